instr_mem_loader: RTL
=====================

# instr_mem_loader

Sequential instruction encoder and writer for the pipelined MIPS core: the producing end of the instruction stream that the control unit decodes. Accepts symbolic instruction requests over a valid/ready handshake, encodes each into a 32-bit MIPS word using the same opcode/funct map the decoder consumes, and writes the words into instruction memory at consecutive word addresses. Sits between the test/boot host and the instruction memory write port, and is active only while the core is held off.

## Interface
- ADDR_W, 8: instruction-memory word-address width.
- BASE_ADDR, 0: first word address written in each session; must be < 2^ADDR_W.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse that opens a load session. Honoured only in IDLE.
- Finish  in  1  one-cycle pulse that closes a session. Honoured only in ACCEPT.
- ReqValid  in  1  request valid.
- ReqReady  out  1  request ready; a transfer occurs when ReqValid & ReqReady.
- ReqOp  in  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 MUL, 6 LW, 7 SW, 8 ADDI, 9 BEQ, 10 J, 11 PUSH, 12 POP, 13 NOP; 14–15 illegal.
- ReqRs / ReqRt / ReqRd  in  5 each  register fields.
- ReqImm  in  16  immediate for I-format.
- ReqTarget  in  26  jump target.
- IMemWE  out  1  instruction-memory write enable.
- IMemAddr  out  ADDR_W  write word address.
- IMemWData  out  32  encoded instruction.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on session end.
- Full  out  1  sticky; the last address has been written.
- Error  out  1  sticky; an illegal ReqOp was accepted.
- Count  out  ADDR_W+1  words written this session.

## Operation
- Encoding uses a fixed map:
  - R-type: {000000, rs, rt, rd, 00000, funct}. Funct values: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, MUL 011100.
  - I-type: {op, rs, rt, imm}. Opcodes: LW 100011, SW 101011, ADDI 001000, BEQ 000100, PUSH 100000, POP 101000.
  - J: {000010, target}.
  - NOP: 32'h0000_0000.
  - Fields that are unused for an op are ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: on Start, go to ACCEPT. Entering ACCEPT sets the address register to BASE_ADDR and clears Count, Full and Error.
  - ACCEPT: ReqReady = ~Finish. If Finish is high, go to DONE; Finish wins over a simultaneous ReqValid and no transfer occurs. On a transfer with a legal op, register the encoded word and go to WRITE. On a transfer with an illegal op, write nothing, set Error, and stay in ACCEPT.
  - WRITE: IMemWE=1 for exactly one cycle, driving the registered address and data. Then Count+1. If the address written was 2^ADDR_W−1, set Full and go to DONE. Otherwise increment the address and return to ACCEPT.
  - DONE: Done=1 for one cycle, then go to IDLE.
- Start outside IDLE is ignored. Finish outside ACCEPT is ignored. Finish arriving during WRITE is dropped, so the host re-issues it.
- Address arithmetic is unsigned, ADDR_W bits. It never wraps: Full terminates the session first.

## Timing
- Reset (RST=0, asynchronous) forces:
  - state IDLE;
  - IMemWE, ReqReady, Busy, Done, Full and Error = 0;
  - Count = 0;
  - IMemAddr = BASE_ADDR;
  - IMemWData = 0.
- Reset mid-WRITE deasserts IMemWE immediately.
- Start at cycle t: Busy and ReqReady are high at t+1.
- Transfer at cycle a:
  - IMemWE, IMemAddr and IMemWData are valid at a+1, with ReqReady low.
  - ReqReady is high again at a+2.
  - Peak throughput is one word per 2 cycles.
- Count, Full and the incremented IMemAddr are updated at a+2.
- Finish at cycle f (in ACCEPT): Done=1 at f+1, Busy=0 at f+2.
- Full and Error hold after DONE until the next Start.

## Test plan
- ADD rd=3 rs=1 rt=2 at BASE_ADDR=0 -> one IMemWE pulse, addr 0, data 0x00221820, Count=1.
- LW rt=8 rs=29 imm=4, then J target=0x10 -> addr 0 data 0x8FA80004, addr 1 data 0x08000010. ReqReady low on each write cycle.
- MUL rd=2 rs=4 rt=5, then ReqOp=14, then NOP:
  - addr 0 data 0x0085101C;
  - the illegal op produces no write and Error=1;
  - NOP written at addr 1 as 0x00000000, Count=2.
- ADDR_W=2, BASE_ADDR=0, ReqValid held high with 5 ADDI requests:
  - exactly 4 writes at addrs 0–3;
  - Full=1 and Done pulse after the 4th write;
  - 5th request never accepted.
- Finish asserted together with ReqValid in ACCEPT -> no transfer, Done the next cycle, IDLE after that. Start during Busy is ignored.
- RST low during a WRITE cycle -> IMemWE drops asynchronously and all outputs take reset values. A new Start then begins again at BASE_ADDR with Count=0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Takes symbolic MIPS instruction requests from the boot/test host, encodes
// each one into a 32-bit instruction word and writes it to instruction memory
// at consecutive word addresses starting at BASE_ADDR. Only active while the
// core is held off.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               pulse: open a load session (IDLE only)
//   i_finish              pulse: close the session (ACCEPT only)
//   i_req_valid           request valid
//   o_req_ready           request ready (transfer = valid & ready)
//   i_req_op              symbolic opcode, 0..13 legal, 14..15 illegal
//   i_req_rs/rt/rd        register fields
//   i_req_imm             16-bit immediate (I-format)
//   i_req_target          26-bit jump target
//   o_imem_we             instruction-memory write enable (one cycle per word)
//   o_imem_addr           write word address
//   o_imem_wdata          encoded instruction word
//   o_busy                high outside IDLE
//   o_done                one-cycle pulse when a session ends
//   o_full                sticky: last address of the memory was written
//   o_error               sticky: an illegal op was accepted
//   o_count               words written in this session
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_start
// ACCEPT | ready for a request unless i_finish is high
// WRITE  | registered word is on the write port for exactly one cycle
// DONE   | o_done pulse, back to IDLE next cycle
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_finish,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_req_op,
  input  logic [4:0]        i_req_rs,
  input  logic [4:0]        i_req_rt,
  input  logic [4:0]        i_req_rd,
  input  logic [15:0]       i_req_imm,
  input  logic [25:0]       i_req_target,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_full,
  output logic              o_error,
  output logic [ADDR_W:0]   o_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LP_BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   LP_CNT_ONE  = (ADDR_W+1)'(1);

  state_t              r_state;
  logic                r_busy;
  logic                r_we;
  logic                r_done;
  logic                r_full;
  logic                r_error;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;

  logic [31:0]         w_word;
  logic                w_legal;

  // Encoder: the same opcode/funct map the decoder in the core consumes.
  always_comb begin
    w_word  = 32'h0000_0000;
    w_legal = 1'b1;
    case (i_req_op)
      4'd0:  w_word = {6'b000000, i_req_rs, i_req_rt, i_req_rd, 5'b00000, 6'b100100}; // AND
      4'd1:  w_word = {6'b000000, i_req_rs, i_req_rt, i_req_rd, 5'b00000, 6'b100101}; // OR
      4'd2:  w_word = {6'b000000, i_req_rs, i_req_rt, i_req_rd, 5'b00000, 6'b100000}; // ADD
      4'd3:  w_word = {6'b000000, i_req_rs, i_req_rt, i_req_rd, 5'b00000, 6'b100010}; // SUB
      4'd4:  w_word = {6'b000000, i_req_rs, i_req_rt, i_req_rd, 5'b00000, 6'b101010}; // SLT
      4'd5:  w_word = {6'b000000, i_req_rs, i_req_rt, i_req_rd, 5'b00000, 6'b011100}; // MUL
      4'd6:  w_word = {6'b100011, i_req_rs, i_req_rt, i_req_imm};                     // LW
      4'd7:  w_word = {6'b101011, i_req_rs, i_req_rt, i_req_imm};                     // SW
      4'd8:  w_word = {6'b001000, i_req_rs, i_req_rt, i_req_imm};                     // ADDI
      4'd9:  w_word = {6'b000100, i_req_rs, i_req_rt, i_req_imm};                     // BEQ
      4'd10: w_word = {6'b000010, i_req_target};                                      // J
      4'd11: w_word = {6'b100000, i_req_rs, i_req_rt, i_req_imm};                     // PUSH
      4'd12: w_word = {6'b101000, i_req_rs, i_req_rt, i_req_imm};                     // POP
      4'd13: w_word = 32'h0000_0000;                                                  // NOP
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
      r_error <= 1'b0;
      r_count <= '0;
      r_addr  <= LP_BASE;
      r_wdata <= 32'h0000_0000;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_ACCEPT;
            r_busy  <= 1'b1;
            r_addr  <= LP_BASE;
            r_count <= '0;
            r_full  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        S_ACCEPT: begin
          // Finish takes priority; ready is low while it is asserted.
          if (i_finish) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (i_req_valid) begin
            if (w_legal) begin
              r_wdata <= w_word;
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_count <= r_count + LP_CNT_ONE;
          // Ending the session at the top address keeps the address from wrapping.
          if (r_addr == LP_ADDR_MAX) begin
            r_full  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_ACCEPT;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Ready must drop in the same cycle Finish is raised, so it is decoded
  // combinationally from the state register and i_finish.
  assign o_req_ready  = (r_state == S_ACCEPT) && !i_finish;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_full       = r_full;
  assign o_error      = r_error;
  assign o_count      = r_count;

endmodule
